reg_dump_engine: RTL

REG_DUMP_ENGINE -- requirements
Module: reg_dump_engine

---
 rtl/reg_dump_engine_pkg.sv | 16 +
 rtl/reg_dump_engine.sv | 109 ++++++++++
 2 files changed

// File: rtl/reg_dump_engine_pkg.sv
// Shared definitions for the register dump engine: FSM encoding and default
// geometry of the CPU register file it scans.
package reg_dump_engine_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_engine.sv
// Walks an external register file index 0..NUM_REGS-1 and streams each word
// out over a valid/ready port, with abort and a one-cycle done pulse.
module reg_dump_engine
  import reg_dump_engine_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);

  // Output handshake: a word transfers on any rising edge where out_valid and
  // out_ready are both high; out_valid/out_data/out_index/out_last hold
  // unchanged until then, and abort overrides a same-cycle transfer.

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] index;

  assign rd_addr   = index;
  assign fsm_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      index     <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            index <= '0;
            busy  <= 1'b1;
            state <= ST_READ;
          end
        end

        ST_READ: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            // Snapshot here so later register writes cannot disturb the word.
            out_data  <= rd_data;
            out_index <= index;
            out_last  <= (index == LAST_IDX);
            out_valid <= 1'b1;
            state     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (index == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              index <= index + 1'b1;
              state <= ST_READ;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
